// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
// Shared definitions for the multiply/divide sequencing controller:
//   state_t          - controller state encoding (IDLE/START/BUSY/WB)
//   EXC_*            - exception codes placed on the writeback data bus
//   RSTATUS_DEFAULT  - register written when an exception is reported
//   TIMEOUT_DEFAULT  - cycles allowed in BUSY before a forced timeout
// -----------------------------------------------------------------------------
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    localparam logic [31:0] EXC_MULT    = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;
    localparam logic [31:0] EXC_TIMEOUT = 32'd6;

    localparam logic [4:0]  RSTATUS_DEFAULT = 5'd30;
    localparam int unsigned TIMEOUT_DEFAULT = 48;

endpackage

// File: rtl/multdiv_ctrl_if.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl_if
// Bundles every non-clock signal of the multiply/divide controller.
//   slave  modport - the controller itself
//   master modport - the pipeline, the arithmetic units and the writeback sink
// Groups:
//   req_*   request from the pipeline (valid/ready handshake)
//   busy    stall indication back to the pipeline
//   ctrl_*  start pulses, unit_op* latched operands to the units
//   mult_*  / div_* unit results, exception and ready flags
//   wb_*    writeback beat (valid/ready handshake)
// -----------------------------------------------------------------------------
interface multdiv_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_is_div;
    logic [31:0] req_opA;
    logic [31:0] req_opB;
    logic [4:0]  req_rd;

    logic        busy;

    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] unit_opA;
    logic [31:0] unit_opB;

    logic [31:0] mult_result;
    logic        mult_exception;
    logic        mult_resultRDY;
    logic [31:0] div_result;
    logic        div_exception;
    logic        div_resultRDY;

    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;

    modport slave (
        input  req_valid, req_is_div, req_opA, req_opB, req_rd,
        output req_ready, busy,
        output ctrl_MULT, ctrl_DIV, unit_opA, unit_opB,
        input  mult_result, mult_exception, mult_resultRDY,
        input  div_result, div_exception, div_resultRDY,
        output wb_valid, wb_rd, wb_data, wb_exception,
        input  wb_ready
    );

    modport master (
        output req_valid, req_is_div, req_opA, req_opB, req_rd,
        input  req_ready, busy,
        input  ctrl_MULT, ctrl_DIV, unit_opA, unit_opB,
        output mult_result, mult_exception, mult_resultRDY,
        output div_result, div_exception, div_resultRDY,
        input  wb_valid, wb_rd, wb_data, wb_exception,
        output wb_ready
    );

endinterface

// File: rtl/timeout_counter.sv
// -----------------------------------------------------------------------------
// timeout_counter
// 6-bit synchronous up-counter used to bound the time an operation spends in
// BUSY. o_tc is high while the count equals TIMEOUT-1.
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset (count -> 0)
//   i_clear  synchronous clear (count -> 0)
//   i_en     increment enable
//   o_tc     terminal count reached
// -----------------------------------------------------------------------------
module timeout_counter
    import multdiv_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam logic [5:0] TC_VALUE = 6'(TIMEOUT - 1);

    logic [5:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 6'd1;
        end
    end

    assign o_tc = (r_count == TC_VALUE);

endmodule

// File: rtl/multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// multdiv_ctrl
// Sequences one multiply or divide at a time between the pipeline and the
// iterative arithmetic units: latches the request, pulses the selected unit's
// start, waits for its ready flag (bounded by TIMEOUT cycles) and returns the
// result or an exception code through a valid/ready writeback port.
// Ports:
//   clock  single clock
//   reset  synchronous active-high reset
//   bus    multdiv_ctrl_if.slave - request, unit, busy and writeback signals
// Parameters:
//   TIMEOUT  maximum cycles spent in BUSY
//   RSTATUS  destination register for any exception
// -----------------------------------------------------------------------------
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter logic [4:0]  RSTATUS = RSTATUS_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_ctrl_if.slave bus
);

    state_t      r_state;
    state_t      w_state_next;

    logic        r_ctrl_mult;
    logic        r_ctrl_div;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [4:0]  r_rd;
    logic        r_is_div;

    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_wb_exc;
    logic        r_wb_suppress;

    logic        w_accept;
    logic        w_unit_rdy;
    logic        w_unit_exc;
    logic [31:0] w_unit_result;
    logic        w_cnt_clear;
    logic        w_cnt_en;
    logic        w_tc;
    logic        w_done_ready;
    logic        w_done_timeout;

    timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_tc    (w_tc)
    );

    // Only the unit selected by the latched opcode is ever looked at.
    always_comb begin
        w_unit_rdy    = r_is_div ? bus.div_resultRDY : bus.mult_resultRDY;
        w_unit_exc    = r_is_div ? bus.div_exception : bus.mult_exception;
        w_unit_result = r_is_div ? bus.div_result    : bus.mult_result;
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_cnt_clear    = 1'b0;
        w_cnt_en       = 1'b0;
        w_done_ready   = 1'b0;
        w_done_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                // Unit ready flags are not sampled here: the unit is restarting.
                w_cnt_clear  = 1'b1;
                w_state_next = ST_BUSY;
            end
            ST_BUSY: begin
                // A ready flag in the terminal-count cycle takes priority.
                if (w_unit_rdy) begin
                    w_done_ready = 1'b1;
                    w_state_next = ST_WB;
                end else begin
                    w_cnt_en = 1'b1;
                    if (w_tc) begin
                        w_done_timeout = 1'b1;
                        w_state_next   = ST_WB;
                    end
                end
            end
            ST_WB: begin
                // A suppressed (r0) beat spends exactly one cycle here.
                if (r_wb_suppress || bus.wb_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ctrl_mult   <= 1'b0;
            r_ctrl_div    <= 1'b0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_rd          <= '0;
            r_is_div      <= 1'b0;
            r_wb_rd       <= '0;
            r_wb_data     <= '0;
            r_wb_exc      <= 1'b0;
            r_wb_suppress <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Start pulses are registered on acceptance so they are high
            // exactly for the single START cycle.
            r_ctrl_mult <= w_accept & ~bus.req_is_div;
            r_ctrl_div  <= w_accept &  bus.req_is_div;

            if (w_accept) begin
                r_op_a   <= bus.req_opA;
                r_op_b   <= bus.req_opB;
                r_rd     <= bus.req_rd;
                r_is_div <= bus.req_is_div;
            end

            if (w_done_ready) begin
                if (w_unit_exc) begin
                    r_wb_rd       <= RSTATUS;
                    r_wb_data     <= r_is_div ? EXC_DIV : EXC_MULT;
                    r_wb_exc      <= 1'b1;
                    r_wb_suppress <= 1'b0;
                end else begin
                    r_wb_rd       <= r_rd;
                    r_wb_data     <= w_unit_result;
                    r_wb_exc      <= 1'b0;
                    r_wb_suppress <= (r_rd == '0);
                end
            end else if (w_done_timeout) begin
                r_wb_rd       <= RSTATUS;
                r_wb_data     <= EXC_TIMEOUT;
                r_wb_exc      <= 1'b1;
                r_wb_suppress <= 1'b0;
            end
        end
    end

    assign bus.req_ready    = (r_state == ST_IDLE);
    assign bus.busy         = (r_state != ST_IDLE);
    assign bus.ctrl_MULT    = r_ctrl_mult;
    assign bus.ctrl_DIV     = r_ctrl_div;
    assign bus.unit_opA     = r_op_a;
    assign bus.unit_opB     = r_op_b;
    assign bus.wb_valid     = (r_state == ST_WB) && !r_wb_suppress;
    assign bus.wb_rd        = r_wb_rd;
    assign bus.wb_data      = r_wb_data;
    assign bus.wb_exception = r_wb_exc;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multdiv_ctrl
// Self-checking bench for multdiv_ctrl: directed scenarios followed by random
// operations, each compared against a behavioural writeback model.
// -----------------------------------------------------------------------------
module tb_multdiv_ctrl;

    localparam int unsigned TIMEOUT = 48;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        exc;
        bit          suppress;
    } exp_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    multdiv_ctrl_if bus ();

    multdiv_ctrl #(
        .TIMEOUT (TIMEOUT),
        .RSTATUS (5'd30)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of run, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Result an ideal arithmetic unit would deliver.
    function automatic logic [31:0] unit_value(input bit is_div, input logic [31:0] a,
                                               input logic [31:0] b);
        if (is_div) return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        return a * b;
    endfunction

    // Writeback expected for one operation outcome.
    function automatic exp_t model(input bit is_div, input logic [4:0] rd,
                                   input logic [31:0] res, input bit unit_exc,
                                   input bit timeout);
        exp_t e;
        e.suppress = 1'b0;
        if (timeout) begin
            e.rd = 5'd30; e.data = 32'd6; e.exc = 1'b1;
        end else if (unit_exc) begin
            e.rd = 5'd30; e.data = is_div ? 32'd5 : 32'd4; e.exc = 1'b1;
        end else begin
            e.rd = rd; e.data = res; e.exc = 1'b0;
            e.suppress = (rd == 5'd0);
        end
        return e;
    endfunction

    task automatic set_unit(input bit sel_div, input logic rdy, input logic [31:0] res,
                            input logic exc);
        if (sel_div) begin
            bus.div_resultRDY  = rdy;
            bus.div_result     = res;
            bus.div_exception  = exc;
            bus.mult_resultRDY = 1'($urandom_range(1, 0));
            bus.mult_result    = $urandom;
            bus.mult_exception = 1'($urandom_range(1, 0));
        end else begin
            bus.mult_resultRDY = rdy;
            bus.mult_result    = res;
            bus.mult_exception = exc;
            bus.div_resultRDY  = 1'($urandom_range(1, 0));
            bus.div_result     = $urandom;
            bus.div_exception  = 1'($urandom_range(1, 0));
        end
    endtask

    task automatic quiet_units();
        bus.mult_resultRDY = 1'b0;
        bus.div_resultRDY  = 1'b0;
        bus.mult_exception = 1'b0;
        bus.div_exception  = 1'b0;
        bus.mult_result    = '0;
        bus.div_result     = '0;
    endtask

    task automatic accept(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        chk("idle_req_ready", bus.req_ready, 1'b1);
        chk("idle_busy", bus.busy, 1'b0);
        bus.req_valid  = 1'b1;
        bus.req_is_div = is_div;
        bus.req_opA    = a;
        bus.req_opB    = b;
        bus.req_rd     = rd;
        step();
        bus.req_valid  = 1'b0;
        bus.req_is_div = 1'($urandom_range(1, 0));
        bus.req_opA    = $urandom;
        bus.req_opB    = $urandom;
        bus.req_rd     = 5'($urandom);
        chk("start_busy", bus.busy, 1'b1);
        chk("start_req_ready", bus.req_ready, 1'b0);
        chk("start_ctrl_MULT", bus.ctrl_MULT, !is_div);
        chk("start_ctrl_DIV", bus.ctrl_DIV, is_div);
        chk("start_unit_opA", bus.unit_opA, a);
        chk("start_unit_opB", bus.unit_opB, b);
        chk("start_wb_valid", bus.wb_valid, 1'b0);
    endtask

    // One full operation. lat = cycles after the start pulse at which the unit
    // raises ready (ignored when timeout is set); stall = cycles wb_ready stays
    // low; spurious = selected ready flag driven high during the START cycle.
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input bit unit_exc, input int unsigned lat,
                          input bit timeout, input int unsigned stall, input bit spurious);
        logic [31:0] res;
        exp_t        e;
        int unsigned wb_c;
        res  = unit_value(is_div, a, b);
        e    = model(is_div, rd, res, unit_exc, timeout);
        wb_c = timeout ? TIMEOUT + 1 : lat + 1;
        accept(is_div, a, b, rd);
        set_unit(is_div, spurious, $urandom, 1'($urandom_range(1, 0)));
        for (int unsigned c = 1; c < wb_c; c++) begin
            step();
            chk("busy_busy", bus.busy, 1'b1);
            chk("busy_req_ready", bus.req_ready, 1'b0);
            chk("busy_ctrl_MULT", bus.ctrl_MULT, 1'b0);
            chk("busy_ctrl_DIV", bus.ctrl_DIV, 1'b0);
            chk("busy_wb_valid", bus.wb_valid, 1'b0);
            chk("busy_unit_opA", bus.unit_opA, a);
            chk("busy_unit_opB", bus.unit_opB, b);
            if (!timeout && c == lat) set_unit(is_div, 1'b1, res, unit_exc);
            else                      set_unit(is_div, 1'b0, $urandom, 1'($urandom_range(1, 0)));
        end
        step();
        quiet_units();
        if (e.suppress) begin
            chk("r0_wb_valid", bus.wb_valid, 1'b0);
            chk("r0_busy", bus.busy, 1'b1);
            step();
            chk("r0_done_busy", bus.busy, 1'b0);
            chk("r0_done_req_ready", bus.req_ready, 1'b1);
            chk("r0_done_wb_valid", bus.wb_valid, 1'b0);
        end else begin
            for (int unsigned s = 0; s <= stall; s++) begin
                chk("wb_valid", bus.wb_valid, 1'b1);
                chk("wb_rd", bus.wb_rd, e.rd);
                chk("wb_data", bus.wb_data, e.data);
                chk("wb_exception", bus.wb_exception, e.exc);
                chk("wb_req_ready", bus.req_ready, 1'b0);
                chk("wb_busy", bus.busy, 1'b1);
                chk("wb_ctrl", {bus.ctrl_MULT, bus.ctrl_DIV}, 2'b00);
                if (s < stall) step();
            end
            bus.wb_ready = 1'b1;
            step();
            bus.wb_ready = 1'b0;
            chk("post_wb_busy", bus.busy, 1'b0);
            chk("post_wb_req_ready", bus.req_ready, 1'b1);
            chk("post_wb_valid", bus.wb_valid, 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_is_div = 1'b0;
        bus.req_opA    = '0;
        bus.req_opB    = '0;
        bus.req_rd     = '0;
        bus.wb_ready   = 1'b0;
        quiet_units();
        step();
        step();

        // Reset state
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_ctrl_MULT", bus.ctrl_MULT, 1'b0);
        chk("rst_ctrl_DIV", bus.ctrl_DIV, 1'b0);
        chk("rst_unit_opA", bus.unit_opA, 32'd0);
        chk("rst_unit_opB", bus.unit_opB, 32'd0);
        chk("rst_wb_valid", bus.wb_valid, 1'b0);
        chk("rst_wb_rd", bus.wb_rd, 5'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_wb_exception", bus.wb_exception, 1'b0);
        reset = 1'b0;
        step();

        // Multiply 7 x 6 -> rd 5, ready 17 cycles after start
        run_op(1'b0, 32'd7, 32'd6, 5'd5, 1'b0, 17, 1'b0, 0, 1'b0);
        // Multiply overflow exception
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 5'd12, 1'b1, 9, 1'b0, 0, 1'b0);
        // Divide 100 / 7 -> rd 9, then divide by zero
        run_op(1'b1, 32'd100, 32'd7, 5'd9, 1'b0, 33, 1'b0, 0, 1'b0);
        run_op(1'b1, 32'd5, 32'd0, 5'd4, 1'b1, 2, 1'b0, 0, 1'b0);
        // Backpressure for 3 cycles; ready asserted during START is ignored
        run_op(1'b0, 32'd123, 32'd456, 5'd17, 1'b0, 4, 1'b0, 3, 1'b1);
        // Write to r0 is swallowed
        run_op(1'b1, 32'd81, 32'd9, 5'd0, 1'b0, 6, 1'b0, 0, 1'b0);
        // Minimum latency and ready coinciding with terminal count
        run_op(1'b0, 32'd3, 32'd11, 5'd1, 1'b0, 1, 1'b0, 0, 1'b1);
        run_op(1'b1, 32'd1000, 32'd10, 5'd31, 1'b0, TIMEOUT, 1'b0, 1, 1'b0);
        // Ready stuck low: timeout exception
        run_op(1'b0, 32'd2, 32'd2, 5'd8, 1'b0, 0, 1'b1, 2, 1'b0);
        run_op(1'b1, 32'd2, 32'd2, 5'd0, 1'b0, 0, 1'b1, 0, 1'b0);

        // Reset five cycles into BUSY, late ready ignored
        accept(1'b1, 32'd50, 32'd3, 5'd3);
        quiet_units();
        for (int unsigned c = 0; c < 5; c++) step();
        chk("pre_rst_busy", bus.busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_req_ready", bus.req_ready, 1'b1);
        chk("mid_rst_wb_valid", bus.wb_valid, 1'b0);
        bus.div_resultRDY = 1'b1;
        bus.div_result    = 32'd16;
        step();
        quiet_units();
        chk("late_rdy_wb_valid", bus.wb_valid, 1'b0);
        chk("late_rdy_busy", bus.busy, 1'b0);
        chk("late_rdy_ctrl_DIV", bus.ctrl_DIV, 1'b0);
        step();
        chk("late_rdy2_wb_valid", bus.wb_valid, 1'b0);
        run_op(1'b1, 32'd50, 32'd3, 5'd3, 1'b0, 3, 1'b0, 0, 1'b0);

        // Random operations
        for (int i = 0; i < 24; i++) begin
            bit          r_div;
            bit          r_exc;
            bit          r_to;
            logic [31:0] r_a;
            logic [31:0] r_b;
            r_div = 1'($urandom_range(1, 0));
            r_exc = ($urandom_range(3, 0) == 0);
            r_to  = ($urandom_range(7, 0) == 0);
            r_a   = ($urandom_range(1, 0) != 0) ? $urandom : 32'($urandom_range(1000, 0));
            r_b   = ($urandom_range(1, 0) != 0) ? $urandom : 32'($urandom_range(50, 1));
            run_op(r_div, r_a, r_b, 5'($urandom), r_exc, $urandom_range(20, 1), r_to,
                   $urandom_range(3, 0), 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencing controller between the processor pipeline and the iterative multiply and divide units. It accepts one multiply or divide request at a time, latches and holds the operands, and pulses the selected unit's start control. It then waits for that unit's ready flag and returns the result, or an exception code, through a valid/ready writeback port. While an operation is in flight it raises `busy` so the pipeline stalls dependent instructions.

## Interface
Parameters:
- `TIMEOUT`, 48: maximum cycles spent in BUSY before the operation is forced to end with an exception.
- `RSTATUS`, 30: destination register written on any exception.

Ports:
- `clock` in 1: single clock for all state.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted this cycle when both it and `req_valid` are high.
- `req_is_div` in 1: 1 = divide, 0 = multiply.
- `req_opA` in 32: multiplicand / dividend.
- `req_opB` in 32: multiplier / divisor.
- `req_rd` in 5: destination register.
- `busy` out 1: high whenever state ≠ IDLE.
- `ctrl_MULT` out 1: one-cycle start pulse to the multiplier.
- `ctrl_DIV` out 1: one-cycle start pulse to the divider.
- `unit_opA` out 32: latched operand A, held stable from START through BUSY.
- `unit_opB` out 32: latched operand B, held stable from START through BUSY.
- `mult_result` in 32, `mult_exception` in 1, `mult_resultRDY` in 1: multiplier outputs.
- `div_result` in 32, `div_exception` in 1, `div_resultRDY` in 1: divider outputs.
- `wb_valid` out 1: writeback beat present.
- `wb_ready` in 1: consumer accepts the writeback beat.
- `wb_rd` out 5: writeback destination register.
- `wb_data` out 32: writeback data.
- `wb_exception` out 1: 1 = `wb_data` carries an exception code.

## Operation
- States: IDLE, START, BUSY, WB.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch opA, opB, rd and is_div, then go to START.
- START:
  - Exactly one cycle.
  - Assert `ctrl_MULT` or `ctrl_DIV` according to the latched is_div.
  - Clear the timeout counter.
  - Go to BUSY.
- BUSY:
  - Sample only the selected unit's ready flag; the other unit's flags are ignored.
  - Ready flags are never sampled in START, because the unit's counter is being reset that cycle.
  - On ready, capture the result and exception into output registers, then go to WB.
  - Otherwise increment the counter. When it reaches `TIMEOUT - 1`, capture an exception of type EXC_TIMEOUT and go to WB.
- Result formation, no unit exception:
  - `wb_rd` = latched rd.
  - `wb_data` = unit result.
  - `wb_exception` = 0.
- Result formation, unit exception:
  - `wb_rd` = `RSTATUS`.
  - `wb_data` = EXC_MULT (4) or EXC_DIV (5).
  - `wb_exception` = 1.
- Result formation, timeout:
  - `wb_rd` = `RSTATUS`.
  - `wb_data` = EXC_TIMEOUT (6).
  - `wb_exception` = 1.
- Writes to r0: a non-exception result with rd = 0 goes through WB with `wb_valid` held low for one cycle, then returns to IDLE. Nothing is written.
- WB:
  - `wb_valid` = 1.
  - `wb_rd`, `wb_data` and `wb_exception` stay stable until `wb_ready`.
  - On `wb_valid && wb_ready`, go to IDLE.
- New requests are never accepted in START, BUSY or WB. `req_ready` = 0 in those states.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready` = 1, `busy` = 0.
  - `ctrl_MULT` = 0, `ctrl_DIV` = 0.
  - `unit_opA` = 0, `unit_opB` = 0.
  - `wb_valid` = 0, `wb_rd` = 0, `wb_data` = 0, `wb_exception` = 0.
  - Timeout counter = 0.
- Latency for a request accepted at edge n (IDLE→START):
  - Start pulse is high during cycle n+1.
  - If the unit raises ready in cycle k (k ≥ n+2), `wb_valid` is high from cycle k+1.
- Start pulses are registered outputs: never high for more than one cycle, never high in any state except START.
- Reset mid-operation, in any state:
  - Next state = IDLE.
  - No writeback is issued.
  - The in-flight unit result is discarded.
  - A ready flag arriving after reset is ignored.
- A ready flag and timeout in the same cycle: ready wins.
- Backpressure: `wb_ready` may stay low indefinitely. The controller holds WB and `busy`, and issues no start pulse.

## Structure
- Shared package `multdiv_pkg` holds:
  - the state encoding (2 bits: IDLE = 0, START = 1, BUSY = 2, WB = 3);
  - the constants EXC_MULT = 4, EXC_DIV = 5, EXC_TIMEOUT = 6;
  - the default RSTATUS = 30.
- Natural sub-module: `timeout_counter`. It is a 6-bit synchronous counter with clear, enable and a terminal-count output compared against `TIMEOUT - 1`.
- All other logic (state register, operand/result registers, output decode) lives in `multdiv_ctrl`.

## Test plan
- Multiply, normal result:
  - Stimulus: mult 7 × 6, rd = 5; multiplier model returns ready 17 cycles after the start pulse.
  - Required: one `ctrl_MULT` pulse; `wb_valid` with rd = 5, data = 42, `wb_exception` = 0; `busy` low the cycle after the handshake.
- Multiply overflow:
  - Stimulus: mult 0x00010000 × 0x00010000, model `mult_exception` = 1.
  - Required: `wb_rd` = 30, `wb_data` = 4, `wb_exception` = 1.
- Divide, normal and divide-by-zero:
  - Stimulus: div 100 / 7, rd = 9; then div 5 / 0, model exception.
  - Required: first gives data = 14, rd = 9; second gives rd = 30, data = 5. `ctrl_MULT` never pulses.
- Backpressure and r0:
  - Stimulus: `wb_ready` held low 3 cycles during a result beat; a separate request with rd = 0.
  - Required: for the backpressured beat, outputs stay stable and `req_ready` stays 0 for those 3 cycles. For the rd = 0 request, `wb_valid` never rises and the controller returns to IDLE.
- Reset in BUSY, and timeout:
  - Stimulus: `reset` asserted 5 cycles into BUSY; separately, ready stuck at 0.
  - Required: after reset, IDLE and `req_ready` = 1 next cycle, no `wb_valid` even when ready arrives later. With ready stuck, exception data = 6 issued exactly `TIMEOUT` cycles after entering BUSY.
